// File: rtl/tl_arbiter_a_if.sv
// tl_arbiter_a_if: per-master A-channel requests and the merged slave-side A port
interface tl_arbiter_a_if #(
    parameter int MASTER_NUM = 2,
    parameter int SOURCE_W   = 8,
    parameter int BEAT_W     = 4,
    parameter int IDX_W      = 2
);
    logic [MASTER_NUM-1:0]               inp_valid_i;
    logic [MASTER_NUM-1:0]               inp_ready_o;
    logic [MASTER_NUM-1:0][SOURCE_W-1:0] inp_source_i;
    logic [MASTER_NUM-1:0][BEAT_W-1:0]   inp_beats_i;
    logic                                oup_valid_o;
    logic                                oup_ready_i;
    logic [SOURCE_W-1:0]                 oup_source_o;
    logic [IDX_W-1:0]                    oup_sel_o;

    modport master (
        output inp_valid_i, inp_source_i, inp_beats_i, oup_ready_i,
        input  inp_ready_o, oup_valid_o, oup_source_o, oup_sel_o
    );

    modport slave (
        input  inp_valid_i, inp_source_i, inp_beats_i, oup_ready_i,
        output inp_ready_o, oup_valid_o, oup_source_o, oup_sel_o
    );
endinterface

// File: rtl/tl_arbiter_a.sv
// tl_arbiter_a: round-robin TileLink A-channel arbiter that locks the grant for a whole message
module tl_arbiter_a #(
    parameter int MASTER_NUM = 2,
    parameter int SOURCE_LSB = 4,
    parameter int SOURCE_MSB = 6,
    parameter int BEAT_W     = 4,
    parameter int SOURCE_W   = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    tl_arbiter_a_if.slave bus
);
    localparam int IDX_W = SOURCE_MSB - SOURCE_LSB;

    if (MASTER_NUM < 2 || MASTER_NUM > (1 << IDX_W) || SOURCE_MSB > SOURCE_W) begin : g_bad_cfg
        $error("tl_arbiter_a: MASTER_NUM must be 2..2**(SOURCE_MSB-SOURCE_LSB) and the index field must fit in the source");
    end

    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]    scan_idx, hi_idx, lo_idx, g;
    logic                hi_hit, lo_hit, g_valid, fire;
    logic [SOURCE_W-1:0] g_src;
    logic [BEAT_W-1:0]   g_beats;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(MASTER_NUM - 1)) ? '0 : i + 1'b1;
    endfunction

    // Pick the first requester at or above rr_ptr, falling back to the lowest one to wrap at MASTER_NUM
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = rr_ptr_q;
        lo_idx = rr_ptr_q;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (bus.inp_valid_i[i]) begin
                lo_hit = 1'b1;
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
        scan_idx = hi_hit ? hi_idx : lo_hit ? lo_idx : rr_ptr_q;
    end

    // Combinational pass-through of the granted master; the grant is frozen outside IDLE
    always_comb begin
        g       = (state_q == IDLE) ? scan_idx : gnt_idx_q;
        g_valid = 1'b0;
        g_src   = '0;
        g_beats = '0;
        bus.inp_ready_o = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (g == IDX_W'(i)) begin
                g_valid = bus.inp_valid_i[i];
                g_src   = bus.inp_source_i[i];
                g_beats = bus.inp_beats_i[i];
                bus.inp_ready_o[i] = !rst_i && bus.oup_ready_i;
            end
        end
        bus.oup_valid_o  = !rst_i && g_valid;
        bus.oup_sel_o    = g;
        bus.oup_source_o = g_src;
        bus.oup_source_o[SOURCE_MSB-1:SOURCE_LSB] = g;
        fire = bus.oup_valid_o && bus.oup_ready_i;
    end

    // Arbitration FSM: a stalled beat holds the grant, a multi-beat message locks it until the last beat
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_idx_d  = gnt_idx_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (fire && g_beats == '0) begin
                    rr_ptr_d = wrap_inc(g);
                end else if (fire) begin
                    state_d    = BURST;
                    gnt_idx_d  = g;
                    beat_cnt_d = g_beats;
                end else if (bus.oup_valid_o) begin
                    state_d   = HOLD;
                    gnt_idx_d = g;
                end
            end
            HOLD: begin
                if (fire && g_beats == '0) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(gnt_idx_q);
                end else if (fire) begin
                    state_d    = BURST;
                    beat_cnt_d = g_beats;
                end
            end
            BURST: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == BEAT_W'(1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = wrap_inc(gnt_idx_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    a_sel_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        state_q != IDLE |-> (bus.oup_sel_o == gnt_idx_q && gnt_idx_d == gnt_idx_q));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == BURST && fire) |-> beat_cnt_q != '0);
    a_ready_onehot: assert property (@(posedge clk_i) $onehot0(bus.inp_ready_o));
endmodule

// File: tb/tb_tl_arbiter_a.sv
// tb_tl_arbiter_a: directed checks of grant order, hold, burst lock and reset for a 4-master arbiter
module tb_tl_arbiter_a;
    localparam int N  = 4;
    localparam int SW = 8;
    localparam int BW = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    tl_arbiter_a_if #(.MASTER_NUM(N), .SOURCE_W(SW), .BEAT_W(BW), .IDX_W(IW)) bus ();

    tl_arbiter_a #(
        .MASTER_NUM(N), .SOURCE_LSB(4), .SOURCE_MSB(6), .BEAT_W(BW), .SOURCE_W(SW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        bus.inp_valid_i = v;
        bus.oup_ready_i = r;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [IW-1:0] sel, input logic [N-1:0] rdy);
        check({tag, "_valid"}, 32'(bus.oup_valid_o), 32'(v));
        check({tag, "_sel"},   32'(bus.oup_sel_o),   32'(sel));
        check({tag, "_ready"}, 32'(bus.inp_ready_o), 32'(rdy));
    endtask

    initial begin
        logic [4:0] rdy_seq;
        int         fires;
        bus.inp_valid_i  = '1;
        bus.oup_ready_i  = 1'b1;
        bus.inp_beats_i  = '0;
        bus.inp_source_i = '0;
        tick;
        tick;
        @(negedge clk);
        check("rst_valid", 32'(bus.oup_valid_o), 32'd0);
        check("rst_ready", 32'(bus.inp_ready_o), 32'd0);
        tick;
        rst = 1'b0;
        drive(4'b0000, 1'b0);
        expect_out("idle0", 1'b0, 2'd0, 4'b0000);

        bus.inp_source_i[2] = 8'h0B;
        tick;
        drive(4'b0100, 1'b1);
        expect_out("single", 1'b1, 2'd2, 4'b0100);
        check("single_src", 32'(bus.oup_source_o), 32'h2B);
        tick;
        drive(4'b0000, 1'b0);
        check("single_rr", 32'(bus.oup_sel_o), 32'd3);

        tick;
        drive(4'b1000, 1'b1);
        check("rr_pre", 32'(bus.oup_sel_o), 32'd3);
        for (int i = 0; i < N; i++) bus.inp_source_i[i] = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            tick;
            drive(4'b1111, 1'b1);
            expect_out($sformatf("rr%0d", i), 1'b1, IW'(i % N), N'(1 << (i % N)));
            check($sformatf("rr%0d_src", i), 32'(bus.oup_source_o), 32'(8'hC3 | ((i % N) << 4)));
        end
        tick;
        drive(4'b0000, 1'b0);
        check("rr_after", 32'(bus.oup_sel_o), 32'd1);

        tick;
        drive(4'b1010, 1'b0);
        expect_out("bp_idle", 1'b1, 2'd1, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            tick;
            drive(4'b1010, 1'b0);
            expect_out($sformatf("bp_hold%0d", i), 1'b1, 2'd1, 4'b0000);
        end
        tick;
        drive(4'b1000, 1'b0);
        expect_out("bp_drop", 1'b0, 2'd1, 4'b0000);
        tick;
        drive(4'b1010, 1'b1);
        expect_out("bp_fire", 1'b1, 2'd1, 4'b0010);
        tick;
        drive(4'b1010, 1'b1);
        expect_out("bp_next", 1'b1, 2'd3, 4'b1000);
        tick;
        drive(4'b0000, 1'b0);
        check("bp_rr", 32'(bus.oup_sel_o), 32'd0);

        bus.inp_beats_i[0] = 4'd3;
        bus.inp_beats_i[1] = 4'd0;
        rdy_seq = 5'b11101;
        fires = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (i == 1) bus.inp_beats_i[0] = 4'd0;
            drive(4'b0011, rdy_seq[i]);
            expect_out($sformatf("burst%0d", i), 1'b1, 2'd0, rdy_seq[i] ? 4'b0001 : 4'b0000);
            if (bus.inp_ready_o[0] && bus.oup_valid_o) fires++;
        end
        check("burst_fires", 32'(fires), 32'd4);
        tick;
        drive(4'b0011, 1'b1);
        expect_out("burst_m1", 1'b1, 2'd1, 4'b0010);
        tick;
        drive(4'b0000, 1'b0);
        check("burst_rr", 32'(bus.oup_sel_o), 32'd2);

        bus.inp_beats_i[2] = 4'd1;
        tick;
        drive(4'b0101, 1'b1);
        expect_out("gap_first", 1'b1, 2'd2, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            tick;
            drive(4'b0001, 1'b1);
            expect_out($sformatf("gap%0d", i), 1'b0, 2'd2, 4'b0100);
        end
        tick;
        drive(4'b0101, 1'b1);
        expect_out("gap_last", 1'b1, 2'd2, 4'b0100);
        tick;
        drive(4'b0001, 1'b1);
        expect_out("gap_m0", 1'b1, 2'd0, 4'b0001);
        tick;
        drive(4'b0000, 1'b0);
        check("gap_rr", 32'(bus.oup_sel_o), 32'd1);

        bus.inp_beats_i[1] = 4'd3;
        for (int i = 0; i < 2; i++) begin
            tick;
            drive(4'b0010, 1'b1);
            expect_out($sformatf("rb%0d", i), 1'b1, 2'd1, 4'b0010);
        end
        tick;
        rst = 1'b1;
        drive(4'b0011, 1'b1);
        check("rb_rst_valid", 32'(bus.oup_valid_o), 32'd0);
        check("rb_rst_ready", 32'(bus.inp_ready_o), 32'd0);
        tick;
        rst = 1'b0;
        drive(4'b0011, 1'b1);
        expect_out("rb_after", 1'b1, 2'd0, 4'b0001);
        tick;
        drive(4'b0000, 1'b0);
        check("rb_rr", 32'(bus.oup_sel_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tl_arbiter_a.md
Name: tl_arbiter_A

Overview:
- TileLink A-channel arbiter: merges request streams from MASTER_NUM masters onto one slave-side A port.
- Selects masters round-robin and holds the grant for the whole multi-beat message.
- Writes the granted master index into source bits [SOURCE_MSB-1:SOURCE_LSB]. The D-channel response router uses those same bits to send the response back to the issuing master.
- Datapath payload (address, data, mask) is muxed outside this block using oup_sel_o.

Parameters:
- MASTER_NUM, 2: number of upstream masters. Legal range is 2 to 2**(SOURCE_MSB-SOURCE_LSB); out-of-range values are an elaboration error.
- SOURCE_LSB, 4: lowest source bit overwritten with the master index.
- SOURCE_MSB, 6: one above the highest overwritten bit. Index width IDX_W = SOURCE_MSB-SOURCE_LSB.
- BEAT_W, 4: width of the beat-count input.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- inp_valid_i  in  MASTER_NUM  per-master A valid.
- inp_ready_o  out  MASTER_NUM  per-master A ready.
- inp_source_i  in  MASTER_NUM x source_t  per-master A source.
- inp_beats_i  in  MASTER_NUM x BEAT_W  beats in the message minus 1; 0 means single beat.
- oup_valid_o  out  1  merged A valid.
- oup_ready_i  in  1  merged A ready.
- oup_source_o  out  source_t  granted source with its index field replaced.
- oup_sel_o  out  IDX_W  granted master index, used for the external payload mux.

Behaviour:
- Handshake:
  - fire = oup_valid_o & oup_ready_i.
  - inp_ready_o[g] = oup_ready_i for the granted master g; all other bits are 0.
  - oup_valid_o = inp_valid_i[g].
- Latency: zero-cycle combinational pass-through of valid, ready and source. Only arbitration state is registered.
- oup_source_o: equals inp_source_i[g] with bits [SOURCE_MSB-1:SOURCE_LSB] = g; all other bits pass through unchanged.
- Registers:
  - state: IDLE, HOLD, BURST.
  - rr_ptr (IDX_W bits).
  - gnt_idx (IDX_W bits).
  - beat_cnt (BEAT_W bits).
- IDLE:
  - g is the first asserted inp_valid_i found scanning upward from rr_ptr, wrapping modulo MASTER_NUM.
  - No valid: oup_valid_o = 0, oup_sel_o = rr_ptr.
  - fire with inp_beats_i[g] == 0: stay IDLE; rr_ptr <= (g+1) mod MASTER_NUM.
  - fire with inp_beats_i[g] > 0: go to BURST; gnt_idx <= g; beat_cnt <= inp_beats_i[g].
  - valid without ready: go to HOLD; gnt_idx <= g.
- HOLD:
  - g = gnt_idx. The grant does not move while the offered beat is pending, because TileLink forbids withdrawing or changing an offered beat.
  - fire with beats == 0: go to IDLE; rr_ptr <= gnt_idx+1 mod MASTER_NUM.
  - fire with beats > 0: go to BURST; beat_cnt <= inp_beats_i[g].
- BURST:
  - g = gnt_idx. inp_beats_i is ignored.
  - Each fire decrements beat_cnt.
  - A fire while beat_cnt == 1 is the last beat: go to IDLE; rr_ptr <= gnt_idx+1 mod MASTER_NUM.
  - Other masters stay blocked for the whole burst, even when the granted master's valid drops between beats.
- Wrap-around: rr_ptr and the pointer scan wrap at MASTER_NUM, not at 2**IDX_W.
- Simultaneous requests: in IDLE, the lowest index at or above rr_ptr (with wrap) wins.
- Reset:
  - While rst_i = 1, oup_valid_o and all inp_ready_o bits are forced to 0.
  - On reset: state <= IDLE, rr_ptr <= 0, gnt_idx <= 0, beat_cnt <= 0.
  - Reset in HOLD or BURST abandons the message; no partial-burst recovery.
- Assertions:
  - In HOLD or BURST, oup_sel_o never changes.
  - beat_cnt never underflows.
  - At most one inp_ready_o bit is set.

Test Plan:
Parameters for all scenarios: MASTER_NUM=4, SOURCE_LSB=4, SOURCE_MSB=6.
- Single master: m2 valid, source=0x0B, beats=0, ready=1. Expected: same-cycle oup_valid=1, oup_source=0x2B, oup_sel=2, inp_ready=0b0100. Next cycle rr_ptr=3.
- Round-robin: all four masters valid with single beats, ready held at 1. Expected grant order 0,1,2,3,0 on consecutive cycles.
- Backpressure hold: m1 and m3 valid, ready=0 for 3 cycles, then m1 valid drop is attempted. Expected: oup_sel stays 1 throughout HOLD and m3 never sees ready. After ready=1, m1 fires, then m3 is granted.
- Burst lock: m0 beats=3, m1 valid, ready toggling 1,0,1,1,1. Expected: exactly 4 m0 fires before any m1 grant, and m1 is granted on the cycle after m0's 4th fire.
- Burst gap: m2 beats=1; its valid drops for 2 cycles between beats while m0 is valid. Expected: oup_valid=0 during the gap, m0 ready stays 0, and the burst completes on m2.
- Reset mid-burst: rst_i is asserted during an m1 BURST with beat_cnt=2. Expected: outputs are 0 during reset. After release, state is IDLE and the first grant follows rr_ptr=0 (m0 wins if valid).
